// File: rtl/hamming_serial_encoder.sv
// hamming_serial_encoder: serial SECDED encoder, K data bits in one per handshake,
// 2^R (EXT=1) or 2^R-1 (EXT=0) codeword bits out one per handshake.
module hamming_serial_encoder #(
    parameter int R   = 4,
    parameter bit EXT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic datain,
    input  logic din_valid,
    output logic din_ready,
    output logic dataout,
    output logic dout_valid,
    input  logic dout_ready,
    output logic dout_first,
    output logic dout_last
);
    localparam int N = 2 ** R;
    localparam logic [R-1:0] WP0   = R'(3);
    localparam logic [R-1:0] START = EXT ? '0 : R'(1);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t         state_q, state_d;
    logic [R-1:0]   wp_q, wp_d, rp_q, rp_d, par_q, par_d, par_n, wp_inc;
    logic           ovr_q, ovr_d, ovr_n;
    logic [N-1:0]   mem_q, mem_d;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        par_d   = par_q;
        ovr_d   = ovr_q;
        mem_d   = mem_q;
        par_n   = par_q ^ (wp_q & {R{datain}});
        ovr_n   = ovr_q ^ datain;
        wp_inc  = wp_q + R'(1);
        if (state_q == LOAD) begin
            if (din_valid) begin
                mem_d[wp_q] = datain;
                par_d       = par_n;
                ovr_d       = ovr_n;
                // skip the next slot when it is a parity position (power of two)
                wp_d        = ((wp_inc & wp_q) == '0) ? wp_q + R'(2) : wp_inc;
                if (&wp_q) begin
                    for (int i = 0; i < R; i++) mem_d[R'(1 << i)] = par_n[i];
                    mem_d[0] = ovr_n ^ (^par_n);
                    par_d    = '0;
                    ovr_d    = 1'b0;
                    rp_d     = START;
                    state_d  = EMIT;
                end
            end
        end else if (dout_ready) begin
            rp_d = rp_q + R'(1);
            if (&rp_q) begin
                state_d = LOAD;
                wp_d    = WP0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            wp_q    <= WP0;
            rp_q    <= '0;
            par_q   <= '0;
            ovr_q   <= 1'b0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            par_q   <= par_d;
            ovr_q   <= ovr_d;
            mem_q   <= mem_d;
        end
    end

    assign din_ready  = (state_q == LOAD);
    assign dout_valid = (state_q == EMIT);
    assign dataout    = dout_valid & mem_q[rp_q];
    assign dout_first = dout_valid & (rp_q == START);
    assign dout_last  = dout_valid & (&rp_q);
endmodule

// File: doc/hamming_serial_encoder.md
# hamming_serial_encoder

Parametrised serial extended-Hamming (SECDED) encoder. It accepts K = 2^R − R − 1 data bits one per handshake, builds an N = 2^R bit codeword, and streams the codeword out one bit per handshake. It is the successor to the fixed 11-bit serial Hamming encoder. It adds generic block size, valid/ready flow control on both sides, frame markers, and an optional overall-parity bit. It sits between a serial data source and the channel/serialiser.

## Interface
Parameters:
- R, 4: number of Hamming parity bits; legal range 2..6. N = 2^R, K = 2^R − R − 1.
- EXT, 1: 1 = emit position 0 (overall parity), giving N bits per frame; 0 = emit positions 1..N−1, giving N−1 bits per frame.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- datain  in  1  serial data bit.
- din_valid  in  1  datain is valid.
- din_ready  out  1  encoder accepts a data bit this cycle.
- dataout  out  1  serial codeword bit.
- dout_valid  out  1  dataout is valid.
- dout_ready  in  1  sink accepts dataout this cycle.
- dout_first  out  1  current dataout is the first bit of a frame.
- dout_last  out  1  current dataout is the last bit of a frame.

## Operation
- The codeword is held in an N-bit register mem[0..N−1], indexed by position.
- Parity positions are 1, 2, 4, ..., 2^(R−1). Position 0 is overall parity. All other positions carry data, in ascending order.
- FSM has two states.
  - LOAD: din_ready = 1.
  - EMIT: dout_valid = 1.
- LOAD:
  - Position counter wp starts at 3.
  - On accept (din_valid & din_ready): mem[wp] <= datain. For every i with wp[i] = 1, par[i] ^= datain. ovr ^= datain.
  - wp then advances: wp+1, or wp+2 if wp+1 is a power of two.
  - The K-th accept (wp = N−1) does all of the following in the same edge:
    - writes mem[2^i] = par[i], using par[i] including the final bit;
    - writes mem[0] = ovr ^ XOR(par), including the final bit;
    - clears par and ovr;
    - sets rp = (EXT ? 0 : 1);
    - moves to EMIT.
- EMIT:
  - dataout = mem[rp]; dout_first = (rp == start); dout_last = (rp == N−1).
  - On transfer (dout_valid & dout_ready): rp++.
  - The transfer with dout_last → LOAD, wp = 3.
- Arithmetic: wp and rp are R bits wide. par is R bits. ovr is 1 bit. All parity is XOR modulo 2.
- din_valid is ignored in EMIT. dout_ready is ignored in LOAD. No data bit is accepted while a frame is emitting (no overlap).
- Outputs are driven only from registered state. There is no combinational path from din_valid or dout_ready to any output.

## Timing
- Reset values, applied immediately on rst assertion:
  - state = LOAD; wp = 3; par = 0; ovr = 0; mem = 0.
  - din_ready = 1, dout_valid = 0, dataout = 0, dout_first = 0, dout_last = 0.
- Latency: dout_valid rises in the cycle after the K-th input accept, with the first codeword bit already on dataout.
- Throughput: a frame takes at least K + N cycles (EXT = 1) or K + N − 1 cycles (EXT = 0).
- Stall behaviour:
  - Input gaps (din_valid = 0) leave all state unchanged.
  - dout_ready = 0 holds dataout, dout_first, dout_last and dout_valid stable.
- din_ready returns to 1 in the cycle after the last output transfer.
- Reset mid-LOAD or mid-EMIT discards the partial frame. Outputs return to their reset values. No partial frame is emitted after rst is released.
- An R = 2 build has K = 1 and N = 4. The first accept is also the last.

## Test plan
- R=4, EXT=1, 11 zero bits, dout_ready=1 → 16 zeros out. dout_first on bit 0, dout_last on bit 15. din_ready is back to 1 one cycle after bit 15.
- R=4, EXT=1, data 1 then 10 zeros (bit at position 3) → stream 1,1,1,1 followed by 12 zeros.
- R=4, EXT=1, only the 11th data bit = 1 (position 15) → stream 1,1,1,0,1,0,0,0,1,0,0,0,0,0,0,1.
- R=4, EXT=1, 11 ones with random din_valid gaps and random dout_ready stalls → 16 ones. dataout and markers stay stable throughout each stall. No bit is duplicated or dropped.
- R=4, EXT=0, data 1 then 10 zeros → 15 bits: 1,1,1 then 12 zeros. dout_first is on position 1.
- Assert rst after 5 accepted bits, release, then send a full zero frame → outputs are at reset values during rst. The next frame is 16 zeros; no residue of the aborted frame appears. Repeat with rst mid-EMIT.
